muldiv_arbiter: RTL and testbench

MULDIV_ARBITER -- requirements
Module: muldiv_arbiter

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_arbiter_rr_arbiter2.sv | 17 +
 rtl/muldiv_arbiter.sv | 152 +++++++++++++++
 tb/tb_muldiv_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the two-requester mul/div arbiter.
package muldiv_pkg;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned OP_W    = 2;

    localparam logic [OP_W-1:0] OP_NONE = 2'd0;
    localparam logic [OP_W-1:0] OP_MUL  = 2'd1;
    localparam logic [OP_W-1:0] OP_DIV  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] src0;
        logic [XLEN-1:0] src1;
        logic [OP_W-1:0] op;
        logic            sign;
    } md_req_t;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin grant; a tie goes to the requester not served last.
module rr_arbiter2
    import muldiv_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               last_served,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        grant = req_valid;
        if (&req_valid) begin
            grant = last_served ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/muldiv_arbiter.sv
// Arbitrates two requesters onto one multi-cycle mul/div datapath, one operation at a time.
// Optional WAIT timeout is enabled by defining MULDIV_ARB_TIMEOUT_EN.
module muldiv_arbiter
    import muldiv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        in_req_valid,
    output logic [NUM_REQ-1:0]        out_req_ready,
    input  logic [NUM_REQ*XLEN-1:0]   in_req_src0,
    input  logic [NUM_REQ*XLEN-1:0]   in_req_src1,
    input  logic [NUM_REQ*OP_W-1:0]   in_req_op,
    input  logic [NUM_REQ-1:0]        in_req_sign,
    output logic                      out_md_start,
    output logic [XLEN-1:0]           out_md_src0,
    output logic [XLEN-1:0]           out_md_src1,
    output logic [OP_W-1:0]           out_md_op,
    output logic                      out_md_sign,
    input  logic                      in_md_busy,
    input  logic [XLEN-1:0]           in_md_res0,
    input  logic [XLEN-1:0]           in_md_res1,
    output logic [NUM_REQ-1:0]        out_resp_valid,
    input  logic [NUM_REQ-1:0]        in_resp_ready,
    output logic [XLEN-1:0]           out_resp_res0,
    output logic [XLEN-1:0]           out_resp_res1,
    output logic                      out_resp_err
);

    state_e              state_q, state_d;
    md_req_t             req_q, req_sel;
    logic                owner_q, last_q;
    logic                start_q, err_q;
    logic [NUM_REQ-1:0]  resp_valid_q, grant;
    logic [XLEN-1:0]     res0_q, res1_q;
    logic                gnt_id, accept, sel_legal, done_ok, timeout_hit, resp_taken;

    rr_arbiter2 u_rr (
        .req_valid   (in_req_valid),
        .last_served (last_q),
        .grant       (grant)
    );

    // Operand mux for whichever requester holds the grant this cycle.
    always_comb begin
        gnt_id       = grant[1];
        req_sel.src0 = gnt_id ? in_req_src0[2*XLEN-1:XLEN] : in_req_src0[XLEN-1:0];
        req_sel.src1 = gnt_id ? in_req_src1[2*XLEN-1:XLEN] : in_req_src1[XLEN-1:0];
        req_sel.op   = gnt_id ? in_req_op[2*OP_W-1:OP_W]   : in_req_op[OP_W-1:0];
        req_sel.sign = gnt_id ? in_req_sign[1]             : in_req_sign[0];
        sel_legal    = op_legal(req_sel.op);
        accept       = (state_q == ST_IDLE) && (|grant);
        done_ok      = (state_q == ST_WAIT) && !in_md_busy;
        resp_taken   = (state_q == ST_RESP) && in_resp_ready[owner_q];
    end

`ifdef MULDIV_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0] to_cnt_q;

    // Counts consecutive busy cycles spent in WAIT.
    always_ff @(posedge clock) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else if ((state_q == ST_WAIT) && in_md_busy) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end else begin
            to_cnt_q <= '0;
        end
    end

    assign timeout_hit = (state_q == ST_WAIT) && in_md_busy
                         && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = sel_legal ? ST_ISSUE : ST_RESP;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (done_ok || timeout_hit) state_d = ST_RESP;
            ST_RESP:  if (resp_taken) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Request latch, start pulse and response capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            req_q        <= '0;
            owner_q      <= 1'b0;
            last_q       <= 1'b1;
            start_q      <= 1'b0;
            resp_valid_q <= '0;
            res0_q       <= '0;
            res1_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            start_q <= accept && sel_legal;
            if (accept) begin
                req_q   <= req_sel;
                owner_q <= gnt_id;
                if (!sel_legal) begin
                    res0_q       <= '0;
                    res1_q       <= '0;
                    err_q        <= 1'b1;
                    resp_valid_q <= gnt_id ? 2'b10 : 2'b01;
                end
            end
            if (done_ok) begin
                res0_q       <= in_md_res0;
                res1_q       <= in_md_res1;
                err_q        <= 1'b0;
                resp_valid_q <= owner_q ? 2'b10 : 2'b01;
            end else if (timeout_hit) begin
                res0_q       <= '0;
                res1_q       <= '0;
                err_q        <= 1'b1;
                resp_valid_q <= owner_q ? 2'b10 : 2'b01;
            end
            if (resp_taken) begin
                resp_valid_q <= '0;
                last_q       <= owner_q;
            end
        end
    end

    assign out_req_ready  = (state_q == ST_IDLE) ? grant : '0;
    assign out_md_start   = start_q;
    assign out_md_src0    = req_q.src0;
    assign out_md_src1    = req_q.src1;
    assign out_md_op      = req_q.op;
    assign out_md_sign    = req_q.sign;
    assign out_resp_valid = resp_valid_q;
    assign out_resp_res0  = res0_q;
    assign out_resp_res1  = res1_q;
    assign out_resp_err   = err_q;

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Directed self-checking bench for muldiv_arbiter; the bench plays the mul/div datapath.
module tb_muldiv_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  in_req_valid, out_req_ready;
    logic [63:0] in_req_src0, in_req_src1;
    logic [3:0]  in_req_op;
    logic [1:0]  in_req_sign;
    logic        out_md_start;
    logic [31:0] out_md_src0, out_md_src1;
    logic [1:0]  out_md_op;
    logic        out_md_sign;
    logic        in_md_busy;
    logic [31:0] in_md_res0, in_md_res1;
    logic [1:0]  out_resp_valid, in_resp_ready;
    logic [31:0] out_resp_res0, out_resp_res1;
    logic        out_resp_err;

    int n_pass  = 0;
    int n_total = 0;

    muldiv_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_req_valid   (in_req_valid),
        .out_req_ready  (out_req_ready),
        .in_req_src0    (in_req_src0),
        .in_req_src1    (in_req_src1),
        .in_req_op      (in_req_op),
        .in_req_sign    (in_req_sign),
        .out_md_start   (out_md_start),
        .out_md_src0    (out_md_src0),
        .out_md_src1    (out_md_src1),
        .out_md_op      (out_md_op),
        .out_md_sign    (out_md_sign),
        .in_md_busy     (in_md_busy),
        .in_md_res0     (in_md_res0),
        .in_md_res1     (in_md_res1),
        .out_resp_valid (out_resp_valid),
        .in_resp_ready  (in_resp_ready),
        .out_resp_res0  (out_resp_res0),
        .out_resp_res1  (out_resp_res1),
        .out_resp_err   (out_resp_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op, input logic sg);
        in_req_src0[32*i +: 32] = a;
        in_req_src1[32*i +: 32] = b;
        in_req_op[2*i +: 2]     = op;
        in_req_sign[i]          = sg;
    endtask

    // Called in the accepting IDLE cycle; walks ISSUE, WAIT and RESP back to IDLE.
    task automatic finish_op(input int owner, input logic [31:0] exp_src0,
                             input logic [31:0] r0, input logic [31:0] r1,
                             input int busy_n, input int hold_n);
        logic [1:0] own_oh, other_oh;
        own_oh   = (owner == 1) ? 2'b10 : 2'b01;
        other_oh = ~own_oh;
        in_md_busy = 1'b1;
        in_md_res0 = r0;
        in_md_res1 = r1;
        tick();
        chk("issue_start", 64'(out_md_start), 64'd1);
        chk("issue_src0", 64'(out_md_src0), 64'(exp_src0));
        chk("issue_ready", 64'(out_req_ready), 64'd0);
        tick();
        chk("wait_start", 64'(out_md_start), 64'd0);
        for (int k = 0; k < busy_n; k++) begin
            chk("wait_rv", 64'(out_resp_valid), 64'd0);
            tick();
        end
        in_md_busy = 1'b0;
        chk("wait_rv_last", 64'(out_resp_valid), 64'd0);
        tick();
        for (int k = 0; k < hold_n; k++) begin
            chk("hold_rv", 64'(out_resp_valid), 64'(own_oh));
            chk("hold_res0", 64'(out_resp_res0), 64'(r0));
            chk("hold_ready", 64'(out_req_ready), 64'd0);
            chk("hold_start", 64'(out_md_start), 64'd0);
            tick();
        end
        in_resp_ready = other_oh;
        chk("resp_rv", 64'(out_resp_valid), 64'(own_oh));
        chk("resp_res0", 64'(out_resp_res0), 64'(r0));
        chk("resp_res1", 64'(out_resp_res1), 64'(r1));
        chk("resp_err", 64'(out_resp_err), 64'd0);
        tick();
        chk("resp_nonowner", 64'(out_resp_valid), 64'(own_oh));
        in_resp_ready = own_oh;
        tick();
        in_resp_ready = 2'b00;
        chk("resp_done", 64'(out_resp_valid), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        in_req_valid  = 2'b00;
        in_req_src0   = '0;
        in_req_src1   = '0;
        in_req_op     = '0;
        in_req_sign   = '0;
        in_md_busy    = 1'b0;
        in_md_res0    = '0;
        in_md_res1    = '0;
        in_resp_ready = 2'b00;
        tick();
        tick();
        chk("rst_start", 64'(out_md_start), 64'd0);
        chk("rst_rv", 64'(out_resp_valid), 64'd0);
        chk("rst_err", 64'(out_resp_err), 64'd0);
        chk("rst_res0", 64'(out_resp_res0), 64'd0);
        chk("rst_md_src0", 64'(out_md_src0), 64'd0);
        reset = 1'b0;

        // Single multiply from requester 0: 7*6.
        set_req(0, 32'd7, 32'd6, 2'd1, 1'b0);
        in_req_valid = 2'b01;
        #1;
        chk("mul_ready", 64'(out_req_ready), 64'd1);
        finish_op(0, 32'd7, 32'd42, 32'd0, 2, 0);
        in_req_valid = 2'b00;
        chk("mul_md_src1", 64'(out_md_src1), 64'd6);
        chk("mul_md_op", 64'(out_md_op), 64'd1);

        // Illegal opcode from requester 1.
        set_req(1, 32'd5, 32'd5, 2'd3, 1'b0);
        in_req_valid = 2'b10;
        #1;
        chk("ill_ready", 64'(out_req_ready), 64'd2);
        tick();
        in_req_valid = 2'b00;
        chk("ill_start", 64'(out_md_start), 64'd0);
        chk("ill_rv", 64'(out_resp_valid), 64'd2);
        chk("ill_err", 64'(out_resp_err), 64'd1);
        chk("ill_res0", 64'(out_resp_res0), 64'd0);
        chk("ill_res1", 64'(out_resp_res1), 64'd0);
        in_resp_ready = 2'b10;
        tick();
        in_resp_ready = 2'b00;
        chk("ill_done", 64'(out_resp_valid), 64'd0);

        // Contention: 100/7 vs -100/7, both signed; grants alternate.
        set_req(0, 32'd100, 32'd7, 2'd2, 1'b1);
        set_req(1, 32'hFFFF_FF9C, 32'd7, 2'd2, 1'b1);
        in_req_valid = 2'b11;
        #1;
        chk("cont_ready_r0", 64'(out_req_ready), 64'd1);
        finish_op(0, 32'd100, 32'd14, 32'd2, 0, 0);
        chk("cont_ready_r1", 64'(out_req_ready), 64'd2);
        finish_op(1, 32'hFFFF_FF9C, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1, 0);
        chk("cont_sign", 64'(out_md_sign), 64'd1);
        chk("cont_ready_r0b", 64'(out_req_ready), 64'd1);

        // Backpressure: response held for five cycles while r1 keeps requesting.
        set_req(0, 32'd3, 32'd5, 2'd1, 1'b0);
        set_req(1, 32'd2, 32'd2, 2'd1, 1'b0);
        finish_op(0, 32'd3, 32'd15, 32'd0, 0, 5);
        in_req_valid = 2'b00;

        // Stuck-busy datapath.
        set_req(0, 32'd9, 32'd9, 2'd1, 1'b0);
        in_req_valid = 2'b01;
        #1;
        tick();
        in_req_valid = 2'b00;
        in_md_busy   = 1'b1;
        chk("stuck_start", 64'(out_md_start), 64'd1);
`ifdef MULDIV_ARB_TIMEOUT_EN
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("to_rv_pending", 64'(out_resp_valid), 64'd0);
        end
        tick();
        chk("to_rv", 64'(out_resp_valid), 64'd1);
        chk("to_err", 64'(out_resp_err), 64'd1);
        chk("to_res0", 64'(out_resp_res0), 64'd0);
        in_resp_ready = 2'b01;
        tick();
        in_resp_ready = 2'b00;
        in_req_valid  = 2'b01;
        #1;
        tick();
        in_req_valid = 2'b00;
        tick();
`else
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("stuck_rv", 64'(out_resp_valid), 64'd0);
        end
`endif

        // Reset while in WAIT, then a fresh request with a tie goes to r0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("wrst_start", 64'(out_md_start), 64'd0);
        chk("wrst_rv", 64'(out_resp_valid), 64'd0);
        chk("wrst_err", 64'(out_resp_err), 64'd0);
        chk("wrst_res0", 64'(out_resp_res0), 64'd0);
        chk("wrst_md_src0", 64'(out_md_src0), 64'd0);
        chk("wrst_md_op", 64'(out_md_op), 64'd0);
        in_md_busy = 1'b0;
        tick();
        chk("wrst_idle_rv", 64'(out_resp_valid), 64'd0);
        in_req_valid = 2'b11;
        #1;
        chk("wrst_ready", 64'(out_req_ready), 64'd1);
        finish_op(0, 32'd9, 32'd81, 32'd0, 1, 0);
        in_req_valid = 2'b00;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
